// File: rtl/pc_sequence_controller.sv
// pc_sequence_controller
// Chooses the program counter command (flagPC/newAddress) each cycle from the
// decoded control-flow op, the branch flags and the stall input. It also owns
// the CALL/RET return-address stack, the fetch-latency bubbles, DELAY
// supervision for WAIT and the HALT state.
module pc_sequence_controller #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 8,
    parameter int FETCH_LAT   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instrValid,
    input  logic [2:0]            pcOp,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  zeroFlag,
    input  logic                  negFlag,
    input  logic                  stall,
    input  logic                  resume,
    input  logic [ADDR_WIDTH-1:0] currentAddress,
    output logic [2:0]            flagPC,
    output logic [ADDR_WIDTH-1:0] newAddress,
    output logic                  accept,
    output logic                  halted,
    output logic                  stackErr
);

    // Pointer runs 0..STACK_DEPTH, so it needs one bit more than the entry index.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = IDX_W + 1;
    localparam int CNT_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_LAT - 1);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_BRN  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_WAIT = 3'd7;

    localparam logic [2:0] PC_HOLD  = 3'd0;
    localparam logic [2:0] PC_INC   = 3'd1;
    localparam logic [2:0] PC_JUMP  = 3'd2;
    localparam logic [2:0] PC_DELAY = 3'd3;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_RUN    = 2'd1,
        S_WAITPC = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Registered PC command presented to the program counter.
    typedef struct packed {
        logic [2:0]            flag;
        logic [ADDR_WIDTH-1:0] addr;
    } pc_cmd_t;

    state_t                               state, state_nx;
    logic [CNT_W-1:0]                     cnt, cnt_nx;
    logic [SP_W-1:0]                      sp;
    logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0] stack_mem;
    logic [ADDR_WIDTH-1:0]                wait_addr;
    pc_cmd_t                              cmd_nx;

    logic                  push, pop, err_set, cap_en;
    logic                  stk_full, stk_empty;
    logic [IDX_W-1:0]      push_idx, top_idx;
    logic [ADDR_WIDTH-1:0] ret_addr, top_addr;

    assign stk_full  = (sp == SP_FULL);
    assign stk_empty = (sp == '0);
    assign push_idx  = IDX_W'(sp);
    assign top_idx   = IDX_W'(sp - 1'b1);
    assign top_addr  = stack_mem[top_idx];
    // Return address wraps naturally at the top of the address space.
    assign ret_addr  = currentAddress + 1'b1;

    // Next-state, next PC command and stack control.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cmd_nx     = '{flag: PC_HOLD, addr: newAddress};
        accept     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        cap_en     = 1'b0;
        unique case (state)
            S_FETCH: begin
                // Bubble after every PC change while the new instruction is fetched.
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                accept = instrValid & ~stall;
                if (accept) begin
                    state_nx = S_FETCH;
                    unique case (pcOp)
                        OP_SEQ: cmd_nx.flag = PC_INC;
                        OP_JMP: cmd_nx = '{flag: PC_JUMP, addr: target};
                        OP_BRZ: begin
                            if (zeroFlag) cmd_nx = '{flag: PC_JUMP, addr: target};
                            else          cmd_nx.flag = PC_INC;
                        end
                        OP_BRN: begin
                            if (negFlag) cmd_nx = '{flag: PC_JUMP, addr: target};
                            else         cmd_nx.flag = PC_INC;
                        end
                        OP_CALL: begin
                            // A full stack drops the call and falls through.
                            if (stk_full) begin
                                cmd_nx.flag = PC_INC;
                                err_set     = 1'b1;
                            end else begin
                                push   = 1'b1;
                                cmd_nx = '{flag: PC_JUMP, addr: target};
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                cmd_nx.flag = PC_INC;
                                err_set     = 1'b1;
                            end else begin
                                pop    = 1'b1;
                                cmd_nx = '{flag: PC_JUMP, addr: top_addr};
                            end
                        end
                        OP_HALT: state_nx = S_HALTED;
                        OP_WAIT: begin
                            cap_en      = 1'b1;
                            cmd_nx.flag = PC_DELAY;
                            state_nx    = S_WAITPC;
                        end
                    endcase
                end
            end
            S_WAITPC: begin
                // Keep the PC in DELAY until it moves off the captured address.
                if (currentAddress != wait_addr) state_nx = S_FETCH;
                else                             cmd_nx.flag = PC_DELAY;
            end
            S_HALTED: begin
                if (resume) state_nx = S_FETCH;
            end
        endcase
    end

    // State, registered outputs, stack pointer and WAIT address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            cnt        <= '0;
            flagPC     <= PC_HOLD;
            newAddress <= '0;
            halted     <= 1'b0;
            stackErr   <= 1'b0;
            sp         <= '0;
            wait_addr  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            flagPC     <= cmd_nx.flag;
            newAddress <= cmd_nx.addr;
            halted     <= (state_nx == S_HALTED);
            if (err_set) stackErr <= 1'b1;
            if (push)      sp <= sp + 1'b1;
            else if (pop)  sp <= sp - 1'b1;
            if (cap_en) wait_addr <= currentAddress;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (push) stack_mem[push_idx] <= ret_addr;
    end

endmodule
